// File: rtl/llc_pkg.sv
// llc_pkg
// Shared definitions for the LLC trace-driven model. It provides:
//   llc_cmd_e         - 4-bit command encoding issued to the LLC controller
//   OFFSET_W, INDEX_W,
//   TAG_W             - default address split for a 64 B line / 16K-set LLC
//   is_legal_op()     - classifies a raw signed parser opcode as legal or not
package llc_pkg;

    typedef enum logic [3:0] {
        RD_L1D   = 4'd0,
        WR_L1D   = 4'd1,
        RD_L1I   = 4'd2,
        SNP_INV  = 4'd3,
        SNP_RD   = 4'd4,
        SNP_WR   = 4'd5,
        SNP_RWIM = 4'd6,
        CLEAR    = 4'd8,
        PRINT    = 4'd9
    } llc_cmd_e;

    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 14;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

    // The parser hands over a C int, so negative values must be rejected.
    // Checking the full 32-bit value, and not only the low nibble, stops an
    // opcode such as 16 from aliasing onto 0.
    function automatic logic is_legal_op(input logic signed [31:0] op);
        return ((op >= 32'sd0) && (op <= 32'sd6)) || (op == 32'sd8) || (op == 32'sd9);
    endfunction

endpackage

// File: rtl/trace_cmd_fifo.sv
// trace_cmd_fifo
// Synchronous FIFO with in-order storage.
//   clk, rst  - rising-edge clock, asynchronous active-high reset (pointers/count)
//   push      - write wdata at the tail (ignored when full)
//   pop       - drop the head entry (ignored when empty)
//   wdata     - entry to write
//   rdata     - current head entry (valid while !empty)
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - number of entries held
// DEPTH must be a power of two so that the pointers wrap naturally.
module trace_cmd_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the head is only observed while count != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/trace_cmd_dispatch.sv
// trace_cmd_dispatch
// Validates parsed trace records, queues legal ones in order and issues them
// to the LLC controller split into tag / index / byte offset. Clear (8) and
// print (9) are ordering barriers: after one is accepted no further record is
// taken until that barrier has been popped.
// Ports:
//   clk, rst                    - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready           - parser handshake
//   in_operation, in_address    - raw signed opcode and address
//   out_valid/out_ready         - controller handshake
//   out_cmd/out_tag/out_index/
//   out_offset                  - head entry, zero while the queue is empty
//   illegal_op                  - one-cycle pulse after an illegal record is dropped
//   occupancy                   - entries held
//   stat_total, stat_illegal    - saturating accept counters
// Build option: define TRACE_CMD_STATS_EN to include the counters; otherwise
// stat_total and stat_illegal are tied to zero.
module trace_cmd_dispatch #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = llc_pkg::OFFSET_W,
    parameter int INDEX_W  = llc_pkg::INDEX_W,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_operation,
    input  logic [ADDR_W-1:0]        in_address,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_cmd,
    output logic [TAG_W-1:0]         out_tag,
    output logic [INDEX_W-1:0]       out_index,
    output logic [OFFSET_W-1:0]      out_offset,
    output logic                     illegal_op,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              stat_total,
    output logic [31:0]              stat_illegal
);

    import llc_pkg::*;

    typedef enum logic {
        RUN     = 1'b0,
        BARRIER = 1'b1
    } state_e;

    localparam int ENTRY_W = 4 + ADDR_W;

    state_e                 state;
    logic signed [31:0]     op_s;
    llc_cmd_e               cmd_in;
    logic                   accept;
    logic                   legal;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [ENTRY_W-1:0]     head;
    logic [ADDR_W-1:0]      head_addr;

    assign op_s   = in_operation;
    assign cmd_in = llc_cmd_e'(in_operation[3:0]);
    assign legal  = is_legal_op(op_s);

    // in_ready depends only on registered state, never on a same-cycle pop.
    assign in_ready  = !full && (state == RUN);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    trace_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_operation[3:0], in_address}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Read side: split the head address, masked to zero while nothing is queued.
    assign head_addr  = out_valid ? head[ADDR_W-1:0] : '0;
    assign out_cmd    = out_valid ? head[ENTRY_W-1 -: 4] : 4'd0;
    assign out_tag    = head_addr[ADDR_W-1 -: TAG_W];
    assign out_index  = head_addr[OFFSET_W +: INDEX_W];
    assign out_offset = head_addr[OFFSET_W-1:0];

    // Barrier FSM. Because nothing is accepted behind a barrier, the barrier
    // is the only entry left when occupancy is 1, so popping at that point
    // releases the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= accept && !legal;
            case (state)
                RUN: begin
                    if (push && (cmd_in == CLEAR || cmd_in == PRINT))
                        state <= BARRIER;
                end
                BARRIER: begin
                    if (pop && (occupancy == 1))
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef TRACE_CMD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_total   <= '0;
            stat_illegal <= '0;
        end else begin
            if (push)              stat_total   <= sat_inc(stat_total);
            if (accept && !legal)  stat_illegal <= sat_inc(stat_illegal);
        end
    end
`else
    assign stat_total   = 32'd0;
    assign stat_illegal = 32'd0;
`endif

endmodule

// File: tb/tb_trace_cmd_dispatch.sv
// tb_trace_cmd_dispatch
// Directed, table-driven bench for trace_cmd_dispatch (DEPTH=8, 32-bit
// address, 12/14/6 tag/index/offset split), plus hand-written sequences for
// full, barrier, streaming and asynchronous-reset behaviour.
module tb_trace_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_operation;
    logic [31:0] in_address;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_cmd;
    logic [11:0] out_tag;
    logic [13:0] out_index;
    logic [5:0]  out_offset;
    logic        illegal_op;
    logic [3:0]  occupancy;
    logic [31:0] stat_total;
    logic [31:0] stat_illegal;

    trace_cmd_dispatch #(
        .DEPTH  (8),
        .ADDR_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_operation (in_operation),
        .in_address   (in_address),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cmd      (out_cmd),
        .out_tag      (out_tag),
        .out_index    (out_index),
        .out_offset   (out_offset),
        .illegal_op   (illegal_op),
        .occupancy    (occupancy),
        .stat_total   (stat_total),
        .stat_illegal (stat_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        iv;
        int          op;
        logic [31:0] addr;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [3:0]  e_cmd;
        logic [11:0] e_tag;
        logic [13:0] e_idx;
        logic [5:0]  e_off;
        int          e_occ;
        logic        e_ill;
    } vec_t;

    vec_t vt[8];

    logic [3:0]  q_cmd[$];
    logic [31:0] q_addr[$];

`ifdef TRACE_CMD_STATS_EN
    localparam logic [31:0] EXP_TOTAL   = 32'd36;
    localparam logic [31:0] EXP_ILLEGAL = 32'd3;
`else
    localparam logic [31:0] EXP_TOTAL   = 32'd0;
    localparam logic [31:0] EXP_ILLEGAL = 32'd0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int op, input logic [31:0] a, input logic r);
        in_valid     = v;
        in_operation = op;
        in_address   = a;
        out_ready    = r;
    endtask

    // Head entry check: address split into 12-bit tag, 14-bit index, 6-bit offset.
    task automatic chk_head(input string name, input logic [3:0] cmd, input logic [31:0] a);
        chk({name, ".valid"},  32'(out_valid),  32'd1);
        chk({name, ".cmd"},    32'(out_cmd),    32'(cmd));
        chk({name, ".tag"},    32'(out_tag),    32'(a[31:20]));
        chk({name, ".index"},  32'(out_index),  32'(a[19:6]));
        chk({name, ".offset"}, 32'(out_offset), 32'(a[5:0]));
    endtask

    initial begin
        //          iv  op   addr          ordy ir  ov  cmd   tag      idx       off    occ ill
        vt[0] = '{1'b1, 0,  32'h1234_5678, 1'b1, 1'b1, 1'b1, 4'd0, 12'h123, 14'h1159, 6'h38, 1, 1'b0};
        vt[1] = '{1'b0, 0,  32'h0,         1'b1, 1'b1, 1'b0, 4'd0, 12'h0,   14'h0,    6'h0,  0, 1'b0};
        vt[2] = '{1'b1, 7,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0,   14'h0,    6'h0,  0, 1'b1};
        vt[3] = '{1'b1, -1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0,   14'h0,    6'h0,  0, 1'b1};
        vt[4] = '{1'b1, 12, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0,   14'h0,    6'h0,  0, 1'b1};
        vt[5] = '{1'b0, 0,  32'h0,         1'b1, 1'b1, 1'b0, 4'd0, 12'h0,   14'h0,    6'h0,  0, 1'b0};
        vt[6] = '{1'b1, 6,  32'hFFFF_FFC0, 1'b0, 1'b1, 1'b1, 4'd6, 12'hFFF, 14'h3FFF, 6'h00, 1, 1'b0};
        vt[7] = '{1'b0, 0,  32'h0,         1'b1, 1'b1, 1'b0, 4'd0, 12'h0,   14'h0,    6'h0,  0, 1'b0};

        // Reset state (asynchronous: visible before any clock edge)
        rst = 1'b1;
        drive(1'b0, 0, 32'h0, 1'b0);
        #1;
        chk("rst.in_ready",  32'(in_ready),   32'd1);
        chk("rst.out_valid", 32'(out_valid),  32'd0);
        chk("rst.out_cmd",   32'(out_cmd),    32'd0);
        chk("rst.out_tag",   32'(out_tag),    32'd0);
        chk("rst.illegal",   32'(illegal_op), 32'd0);
        chk("rst.occ",       32'(occupancy),  32'd0);
        chk("rst.total",     stat_total,      32'd0);
        chk("rst.illegal_n", stat_illegal,    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table: single accept with 1-cycle latency, illegal opcodes, max address
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].iv, vt[i].op, vt[i].addr, vt[i].ordy);
            tick();
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready),   32'(vt[i].e_ir));
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d.occ", i),      32'(occupancy),  32'(vt[i].e_occ));
            chk($sformatf("vec%0d.illegal", i),  32'(illegal_op), 32'(vt[i].e_ill));
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d.cmd", i),    32'(out_cmd),    32'(vt[i].e_cmd));
                chk($sformatf("vec%0d.tag", i),    32'(out_tag),    32'(vt[i].e_tag));
                chk($sformatf("vec%0d.index", i),  32'(out_index),  32'(vt[i].e_idx));
                chk($sformatf("vec%0d.offset", i), 32'(out_offset), 32'(vt[i].e_off));
            end
        end
        chk("illegal.stat", stat_illegal, EXP_ILLEGAL);

        // Fill to DEPTH with out_ready low; ninth record is held off
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i % 7, 32'h1000_0000 + 32'(i * 64), 1'b0);
            tick();
            chk($sformatf("fill%0d.occ", i),      32'(occupancy), 32'(i + 1));
            chk($sformatf("fill%0d.in_ready", i), 32'(in_ready),  (i < 7) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 5, 32'h1000_0200, 1'b0);
        tick();
        chk("full.hold.occ",      32'(occupancy), 32'd8);
        chk("full.hold.in_ready", 32'(in_ready),  32'd0);
        drive(1'b0, 0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk_head($sformatf("drain%0d", i), 4'(i % 7), 32'h1000_0000 + 32'(i * 64));
            tick();
        end
        chk("drain.occ",       32'(occupancy), 32'd0);
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Barrier: op 1, op 9, op 2 with out_ready low
        drive(1'b1, 1, 32'h0000_0040, 1'b0);
        tick();
        chk("bar.a.occ", 32'(occupancy), 32'd1);
        chk("bar.a.ir",  32'(in_ready),  32'd1);
        drive(1'b1, 9, 32'h0000_0080, 1'b0);
        tick();
        chk("bar.b.occ", 32'(occupancy), 32'd2);
        chk("bar.b.ir",  32'(in_ready),  32'd0);
        drive(1'b1, 2, 32'h0000_00C0, 1'b0);
        tick();
        chk("bar.c.occ", 32'(occupancy), 32'd2);
        chk("bar.c.ir",  32'(in_ready),  32'd0);
        chk_head("bar.c", 4'd1, 32'h0000_0040);
        out_ready = 1'b1;
        tick();
        chk("bar.d.occ", 32'(occupancy), 32'd1);
        chk("bar.d.ir",  32'(in_ready),  32'd0);
        chk_head("bar.d", 4'd9, 32'h0000_0080);
        tick();
        chk("bar.e.occ", 32'(occupancy), 32'd0);
        chk("bar.e.ir",  32'(in_ready),  32'd1);
        chk("bar.e.ov",  32'(out_valid), 32'd0);
        tick();
        chk("bar.f.occ", 32'(occupancy), 32'd1);
        chk_head("bar.f", 4'd2, 32'h0000_00C0);
        drive(1'b0, 0, 32'h0, 1'b1);
        tick();
        chk("bar.g.occ", 32'(occupancy), 32'd0);

        // Streaming at occupancy 3 for 20 cycles (pointers wrap several times)
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 32'h2000_0000 + 32'(i * 64) + 32'(i), 1'b0);
            q_cmd.push_back(4'(i));
            q_addr.push_back(32'h2000_0000 + 32'(i * 64) + 32'(i));
            tick();
        end
        chk("stream.pre.occ", 32'(occupancy), 32'd3);
        for (int i = 0; i < 20; i++) begin
            int          op;
            logic [31:0] a;
            op = (3 + i) % 7;
            a  = 32'h3000_0000 + 32'(i * 4160) + 32'(i);
            drive(1'b1, op, a, 1'b1);
            chk_head($sformatf("stream%0d", i), q_cmd[0], q_addr[0]);
            tick();
            void'(q_cmd.pop_front());
            void'(q_addr.pop_front());
            q_cmd.push_back(4'(op));
            q_addr.push_back(a);
            chk($sformatf("stream%0d.occ", i), 32'(occupancy), 32'd3);
        end
        drive(1'b0, 0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_head($sformatf("stail%0d", i), q_cmd[0], q_addr[0]);
            tick();
            void'(q_cmd.pop_front());
            void'(q_addr.pop_front());
        end
        chk("stream.post.occ", 32'(occupancy), 32'd0);
        chk("stat.total",   stat_total,   EXP_TOTAL);
        chk("stat.illegal", stat_illegal, EXP_ILLEGAL);

        // Asynchronous reset with 5 entries and a pending barrier
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i + 3, 32'h4000_0000 + 32'(i * 64), 1'b0);
            tick();
        end
        drive(1'b1, 8, 32'h4000_1000, 1'b0);
        tick();
        drive(1'b0, 0, 32'h0, 1'b0);
        chk("prerst.occ", 32'(occupancy), 32'd5);
        chk("prerst.ir",  32'(in_ready),  32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.occ",   32'(occupancy),  32'd0);
        chk("arst.ov",    32'(out_valid),  32'd0);
        chk("arst.ir",    32'(in_ready),   32'd1);
        chk("arst.cmd",   32'(out_cmd),    32'd0);
        chk("arst.total", stat_total,      32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 3, 32'h5555_5555, 1'b1);
        tick();
        chk("post.occ", 32'(occupancy), 32'd1);
        chk_head("post", 4'd3, 32'h5555_5555);
        drive(1'b0, 0, 32'h0, 1'b1);
        tick();
        chk("post.drain.occ", 32'(occupancy), 32'd0);
        chk("post.ir",        32'(in_ready),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_cmd_dispatch.md
# trace_cmd_dispatch

Sits directly downstream of the trace parser in the LLC trace-driven model. It accepts one parsed trace record per handshake, as a 32-bit operation code plus a 32-bit address. It validates the opcode and splits the address into tag/index/byte-offset. Commands are buffered in order in a small FIFO and issued to the LLC controller over a valid/ready interface. Clear (8) and print (9) act as ordering barriers.

## Interface
- DEPTH, 8: FIFO entries. Power of two, ≥2.
- ADDR_W, 32: address width.
- OFFSET_W, 6: byte-offset bits (64 B line).
- INDEX_W, 14: set-index bits (16K sets).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W: tag bits (12).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  parser record valid.
- in_ready  out  1  block can accept a record.
- in_operation  in  32  trace opcode (signed int from parser).
- in_address  in  ADDR_W  trace address.
- out_valid  out  1  command available to LLC controller.
- out_ready  in  1  controller accepts command.
- out_cmd  out  4  opcode of head entry.
- out_tag  out  TAG_W  address[ADDR_W-1 -: TAG_W].
- out_index  out  INDEX_W  address[OFFSET_W +: INDEX_W].
- out_offset  out  OFFSET_W  address[OFFSET_W-1:0].
- illegal_op  out  1  one-cycle pulse when a record with an illegal opcode is dropped.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- stat_total  out  32  accepted legal commands.
- stat_illegal  out  32  dropped illegal records.

## Operation
- Legal opcodes: 0–6, 8, 9. Any other in_operation value is illegal, including negatives, 7, and >9.
- Input accept: in_valid && in_ready at a rising edge.
  - Legal record: written to the FIFO tail.
  - Illegal record: consumed but not stored. illegal_op pulses high for the following cycle.
- in_ready = !full && (state == RUN). It does not depend on a same-cycle pop.
- Output issue: out_valid && out_ready at a rising edge pops the head.
  - out_* hold the head entry while out_valid=1. They must stay stable until popped.
- FSM states:
  - RUN: accepting input.
  - BARRIER: in_ready=0, waiting for the barrier command to drain.
- Transitions:
  - RUN → BARRIER when a legal opcode 8 or 9 is accepted.
  - BARRIER → RUN on the edge that pops that barrier entry. in_ready=1 from the next cycle.
  - No record is accepted while a barrier is queued, so the barrier is always the tail entry.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- Full: in_ready=0. Empty: out_valid=0. Read and write pointers wrap modulo DEPTH.
- Reset values:
  - in_ready=1, out_valid=0, out_cmd/out_tag/out_index/out_offset=0.
  - illegal_op=0, occupancy=0, counters=0, state=RUN.
- Reset mid-operation discards all queued entries, including a pending barrier.

## Timing
- Record accepted at edge k appears on out_* with out_valid=1 in the cycle after edge k, provided the FIFO was empty. This is 1-cycle latency.
- There is no combinational path from in_* to out_*, or from out_ready to in_ready.
- Sustained throughput is one command per cycle when out_ready=1 and no barrier is pending.
- occupancy and counters update on the edge of the push or pop.

## Configuration
- TRACE_CMD_STATS_EN defined:
  - stat_total increments on each legal accept.
  - stat_illegal increments on each illegal accept.
  - Both counters saturate at 32'hFFFF_FFFF.
- TRACE_CMD_STATS_EN undefined:
  - Counter logic is omitted and stat_total/stat_illegal are tied to 0.
  - All other behaviour is identical.

## Structure
- Shared package llc_pkg holds:
  - Typedef llc_cmd_e (4-bit enum): RD_L1D=0, WR_L1D=1, RD_L1I=2, SNP_INV=3, SNP_RD=4, SNP_WR=5, SNP_RWIM=6, CLEAR=8, PRINT=9.
  - Constants OFFSET_W, INDEX_W, TAG_W.
  - Function is_legal_op().
- One sub-module, trace_cmd_fifo: a parameterized synchronous FIFO with push/pop/full/empty/count, holding {cmd, address}.
- Address splitting happens on the FIFO read side.

## Test plan
- Reset, then accept op 0 at 0x1234_5678 with out_ready=1. Required: next cycle out_cmd=0, out_tag=0x123, out_index=0x1159, out_offset=0x38; occupancy returns to 0 after the pop.
- out_ready=0, push 9 consecutive legal reads (DEPTH=8). Required: in_ready=0 after the 8th accept, occupancy=8. Then raise out_ready: commands pop in order.
- Push op 7, then op -1, then op 12. Required: three illegal_op pulses, occupancy=0, stat_illegal=3 (with macro) or 0 (without).
- Push op 1, op 9, op 2 back-to-back with out_ready=0. Required: in_ready drops after op 9 and op 2 is held off. Release out_ready: op 9 pops and in_ready=1 the next cycle, then op 2 is accepted.
- Continuous push and pop at occupancy=3 for 20 cycles. Required: occupancy stays at 3, pointers wrap, and the data order is preserved.
- Assert rst with 5 entries and a pending barrier. Required: occupancy=0, out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
